mips_fetch_unit: RTL and testbench
==================================

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 PCWrite, PCWriteCond, EQorNE, IorD, IRWrite  in  1 each  control strobes from the multicycle controller.
REQ-005 PCSource  in  2  next-PC select.
REQ-006 alu_result  in  32  combinational ALU output.
REQ-007 alu_zero  in  1  combinational ALU zero flag.
REQ-008 rs_data  in  32  register-file port A value (JR target).
REQ-009 mem_rdata  in  32  memory read data.
REQ-010 mem_addr  out  32  memory address.
REQ-011 pc  out  32  current PC register.
REQ-012 alu_out  out  32  registered ALU result (ALUOut).
REQ-013 mdr  out  32  registered memory data (MDR).
REQ-014 op_code, funct  out  6 each  IR[31:26], IR[5:0].
REQ-015 rs, rt, rd, shamt  out  5 each  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
REQ-016 imm_sext, imm_zext  out  32 each  IR[15:0] sign-/zero-extended.
REQ-017 imm_shift  out  32  imm_sext << 2 (branch offset).
REQ-018 jump_target  out  32  {pc[31:28], IR[25:0], 2'b00}.
REQ-019 misaligned  out  1  sticky alignment error flag.
REQ-020 instr_count  out  32  retired-fetch counter.

Function
REQ-021 mem_addr SHALL equal alu_out when IorD=1, otherwise pc; combinational.
REQ-022 alu_out SHALL load alu_result every cycle; mdr SHALL load mem_rdata every cycle.
REQ-023 zero_q SHALL register alu_zero every cycle.
REQ-024 Next PC: PCSource 00 -> alu_result; 01 -> alu_out; 10 -> jump_target; 11 -> rs_data.
REQ-025 pc SHALL load next PC when PCWrite=1, or when PCWriteCond=1 and zero_q equals EQorNE (EQorNE=1 -> branch if equal, 0 -> branch if not equal).
REQ-026 PCWrite=1 SHALL override the PCWriteCond condition; with both 0, pc holds.
REQ-027 IR SHALL load mem_rdata when IRWrite=1, otherwise hold; all decoded outputs derive combinationally from IR (jump_target also from pc).
REQ-028 jump_target SHALL use pc as currently registered, i.e. already incremented by fetch.
REQ-029 instr_count SHALL increment by 1 on each cycle with IRWrite=1; wraps 32'hFFFF_FFFF -> 0.
REQ-030 misaligned SHALL set on any cycle where mem_addr[1:0] != 2'b00 and IRWrite=1 or IorD=1; remains set until rst.
REQ-031 A next-PC value with bits [1:0] != 0 SHALL still be loaded; only misaligned reports it.
REQ-032 IRWrite and PCWrite in the same cycle (fetch) SHALL load IR from mem_rdata addressed by the old pc.

Reset
REQ-033 On rst: pc=RESET_PC, IR=0, alu_out=0, mdr=0, zero_q=0, instr_count=0, misaligned=0.
REQ-034 rst SHALL take priority over every strobe in the same cycle, including mid-instruction.
REQ-035 After rst with IR=0, decoded outputs SHALL be all zero (op_code=R_TYPE, funct=0).

Structure
REQ-036 PCSource encodings and RESET_PC default SHALL live in the shared MIPS defines file with the opcode/state constants.
REQ-037 Instruction field extraction SHALL be one sub-module, mips_ir_decode (IR and pc in, fields out, purely combinational).

Verification
REQ-038 rst, then PCWrite=1, PCSource=00, alu_result=4, IRWrite=1, mem_rdata=32'h2008_0005 -> pc=4, op_code=6'h08, rt=8, imm_sext=5, instr_count=1.
REQ-039 alu_zero=1 one cycle, then PCWriteCond=1, EQorNE=1, PCSource=01, prior alu_out=32'h40 -> pc=32'h40; repeat with EQorNE=0 -> pc unchanged.
REQ-040 pc=32'h1000_0004, IR=32'h0800_0010, PCWrite=1, PCSource=10 -> pc=32'h1000_0040.
REQ-041 IR imm=16'h8000 -> imm_sext=32'hFFFF_8000, imm_zext=32'h0000_8000, imm_shift=32'hFFFE_0000.
REQ-042 IorD=1, alu_out=32'h0000_0102 -> mem_addr=32'h102, misaligned=1 and stays 1 until rst.
REQ-043 rst asserted together with PCWrite=1, IRWrite=1 -> pc=RESET_PC, IR=0, instr_count=0 next cycle.

Source files
------------

// File: rtl/mips_fetch_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_fetch_unit_pkg                                              |
// | Shared MIPS defines: PC source encodings, reset PC, opcodes and  |
// | multicycle controller state encodings.                           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mips_fetch_unit_pkg;

  // PC value after reset unless the instantiating design overrides it
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Next-PC source select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,  // PC + 4 computed this cycle
    PCSRC_ALUOUT = 2'b01,  // branch target computed in decode
    PCSRC_JUMP   = 2'b10,  // J/JAL pseudo-direct target
    PCSRC_JR     = 2'b11   // register target
  } pc_src_e;

  // Primary opcodes
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // Multicycle controller states
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_ir_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_ir_decode                                                   |
// | Purely combinational field extraction from the instruction       |
// | register, plus the pseudo-direct jump target.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mips_ir_decode
  import mips_fetch_unit_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  output logic [5:0]  op_code,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [31:0] imm_sext,
  output logic [31:0] imm_zext,
  output logic [31:0] imm_shift,
  output logic [31:0] jump_target
);

  // Only the region nibble of pc feeds the jump target
  logic unused_pc_low;
  assign unused_pc_low = ^pc[27:0];

  // Field slicing and immediate extension
  always_comb begin
    op_code     = ir[31:26];
    rs          = ir[25:21];
    rt          = ir[20:16];
    rd          = ir[15:11];
    shamt       = ir[10:6];
    funct       = ir[5:0];
    imm_sext    = {{16{ir[15]}}, ir[15:0]};
    imm_zext    = {16'h0000, ir[15:0]};
    imm_shift   = {{14{ir[15]}}, ir[15:0], 2'b00};
    // pc has already been advanced by fetch, so this is the delay-slot region
    jump_target = {pc[31:28], ir[25:0], 2'b00};
  end

endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_fetch_unit                                                  |
// | Multicycle MIPS datapath front end: PC, IR, ALUOut, MDR, zero    |
// | flag register, fetch counter and sticky alignment check.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        EQorNE,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [1:0]  PCSource,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] alu_out,
  output logic [31:0] mdr,
  output logic [5:0]  op_code,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [31:0] imm_sext,
  output logic [31:0] imm_zext,
  output logic [31:0] imm_shift,
  output logic [31:0] jump_target,
  output logic        misaligned,
  output logic [31:0] instr_count
);

  logic [31:0] ir_q;
  logic        zero_q;
  logic [31:0] next_pc;
  logic        pc_load;
  logic        addr_bad;

  // Memory address, next-PC mux, PC enable and alignment detect
  always_comb begin
    mem_addr = IorD ? alu_out : pc;
    next_pc  = alu_result;
    case (PCSource)
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = jump_target;
      PCSRC_JR:     next_pc = rs_data;
      default:      next_pc = alu_result;
    endcase
    // Unconditional write wins; a conditional write compares the flag
    // registered last cycle against the requested polarity
    pc_load  = PCWrite | (PCWriteCond & (zero_q == EQorNE));
    addr_bad = (mem_addr[1:0] != 2'b00) & (IRWrite | IorD);
  end

  // Architectural state; reset dominates every strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir_q        <= 32'h0000_0000;
      alu_out     <= 32'h0000_0000;
      mdr         <= 32'h0000_0000;
      zero_q      <= 1'b0;
      instr_count <= 32'h0000_0000;
      misaligned  <= 1'b0;
    end else begin
      alu_out <= alu_result;
      mdr     <= mem_rdata;
      zero_q  <= alu_zero;
      // Misaligned targets are still taken; only the flag reports them
      if (pc_load) begin
        pc <= next_pc;
      end
      // Memory was addressed by the old pc, so a fetch latches the right word
      if (IRWrite) begin
        ir_q        <= mem_rdata;
        instr_count <= instr_count + 32'd1;
      end
      if (addr_bad) begin
        misaligned <= 1'b1;
      end
    end
  end

  mips_ir_decode u_ir_decode (
    .ir          (ir_q),
    .pc          (pc),
    .op_code     (op_code),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm_sext    (imm_sext),
    .imm_zext    (imm_zext),
    .imm_shift   (imm_shift),
    .jump_target (jump_target)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mips_fetch_unit                                               |
// | Directed table-driven bench for mips_fetch_unit.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mips_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        PCWrite, PCWriteCond, EQorNE, IorD, IRWrite;
  logic [1:0]  PCSource;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, pc, alu_out, mdr;
  logic [5:0]  op_code, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext, imm_shift, jump_target;
  logic        misaligned;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  mips_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .EQorNE      (EQorNE),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .pc          (pc),
    .alu_out     (alu_out),
    .mdr         (mdr),
    .op_code     (op_code),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm_sext    (imm_sext),
    .imm_zext    (imm_zext),
    .imm_shift   (imm_shift),
    .jump_target (jump_target),
    .misaligned  (misaligned),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, pcwc, eqne, iord, irw;
    logic [1:0]  src;
    logic [31:0] alu_res;
    logic        zero;
    logic [31:0] rs_d, mrd;
    logic [31:0] e_pc, e_cnt;
    logic [5:0]  e_op;
    logic [31:0] e_sext;
    logic        e_mis;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic pcw, pcwc, eqne, iord, irw, input logic [1:0] src,
    input logic [31:0] alu_res, input logic zero, input logic [31:0] rs_d, mrd,
    input logic [31:0] e_pc, e_cnt, input logic [5:0] e_op,
    input logic [31:0] e_sext, input logic e_mis);
    vec_t v;
    v.pcw = pcw; v.pcwc = pcwc; v.eqne = eqne; v.iord = iord; v.irw = irw;
    v.src = src; v.alu_res = alu_res; v.zero = zero; v.rs_d = rs_d; v.mrd = mrd;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_op = e_op; v.e_sext = e_sext; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    PCWrite = 0; PCWriteCond = 0; EQorNE = 0; IorD = 0; IRWrite = 0;
    PCSource = 2'b00; alu_result = 0; alu_zero = 0; rs_data = 0; mem_rdata = 0;
  endtask

  // Inputs change on the falling edge; results are sampled one falling edge later
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Table: each row is one clock with its expected post-edge state
    vecs[0]  = mk(1,0,0,0,1,2'd0, 32'h4,       0, 0,            32'h2008_0005, 32'h4,         1, 6'h08, 32'h5,         0);
    vecs[1]  = mk(0,0,0,0,0,2'd0, 32'h40,      1, 0,            0,             32'h4,         1, 6'h08, 32'h5,         0);
    vecs[2]  = mk(0,1,1,0,0,2'd1, 32'h0,       0, 0,            0,             32'h40,        1, 6'h08, 32'h5,         0);
    vecs[3]  = mk(0,0,0,0,0,2'd0, 32'h80,      1, 0,            0,             32'h40,        1, 6'h08, 32'h5,         0);
    vecs[4]  = mk(0,1,0,0,0,2'd1, 32'h0,       0, 0,            0,             32'h40,        1, 6'h08, 32'h5,         0);
    vecs[5]  = mk(0,1,0,0,0,2'd0, 32'h48,      0, 0,            0,             32'h48,        1, 6'h08, 32'h5,         0);
    vecs[6]  = mk(0,1,1,0,0,2'd0, 32'h99,      0, 0,            0,             32'h48,        1, 6'h08, 32'h5,         0);
    vecs[7]  = mk(1,1,1,0,0,2'd3, 32'h0,       0, 32'h1000_0004, 0,            32'h1000_0004, 1, 6'h08, 32'h5,         0);
    vecs[8]  = mk(0,0,0,0,1,2'd0, 32'h0,       0, 0,            32'h0800_0010, 32'h1000_0004, 2, 6'h02, 32'h10,        0);
    vecs[9]  = mk(1,0,0,0,0,2'd2, 32'h0,       0, 0,            0,             32'h1000_0040, 2, 6'h02, 32'h10,        0);
    vecs[10] = mk(1,0,0,0,1,2'd0, 32'h1000_0044, 0, 0,          32'h3C01_8000, 32'h1000_0044, 3, 6'h0F, 32'hFFFF_8000, 0);
    vecs[11] = mk(1,0,0,0,0,2'd0, 32'h1000_0046, 0, 0,          0,             32'h1000_0046, 3, 6'h0F, 32'hFFFF_8000, 0);
    vecs[12] = mk(0,0,0,0,1,2'd0, 32'h0,       0, 0,            0,             32'h1000_0046, 4, 6'h00, 32'h0,         1);

    rst = 1'b0;
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_pc",        pc,          TB_RESET_PC);
    chk("rst_alu_out",   alu_out,     32'h0);
    chk("rst_mdr",       mdr,         32'h0);
    chk("rst_count",     instr_count, 32'h0);
    chk("rst_mis",       {31'b0, misaligned}, 32'h0);
    chk("rst_op",        {26'b0, op_code}, 32'h0);
    chk("rst_funct",     {26'b0, funct},   32'h0);
    chk("rst_sext",      imm_sext,    32'h0);
    chk("rst_mem_addr",  mem_addr,    TB_RESET_PC);
    chk("rst_jtarget",   jump_target, 32'hB000_0000);

    for (int i = 0; i < 13; i++) begin
      PCWrite = vecs[i].pcw; PCWriteCond = vecs[i].pcwc; EQorNE = vecs[i].eqne;
      IorD = vecs[i].iord; IRWrite = vecs[i].irw; PCSource = vecs[i].src;
      alu_result = vecs[i].alu_res; alu_zero = vecs[i].zero;
      rs_data = vecs[i].rs_d; mem_rdata = vecs[i].mrd;
      step();
      chk($sformatf("v%0d_pc", i),    pc,                 vecs[i].e_pc);
      chk($sformatf("v%0d_count", i), instr_count,        vecs[i].e_cnt);
      chk($sformatf("v%0d_op", i),    {26'b0, op_code},   {26'b0, vecs[i].e_op});
      chk($sformatf("v%0d_sext", i),  imm_sext,           vecs[i].e_sext);
      chk($sformatf("v%0d_mis", i),   {31'b0, misaligned}, {31'b0, vecs[i].e_mis});
    end

    // Reset clears the sticky flag
    do_reset();
    chk("mis_cleared", {31'b0, misaligned}, 32'h0);

    // Immediate extension of a negative halfword, and MDR capture
    idle_inputs();
    IRWrite = 1; mem_rdata = 32'h3C01_8000;
    step();
    chk("imm_sext",  imm_sext,  32'hFFFF_8000);
    chk("imm_zext",  imm_zext,  32'h0000_8000);
    chk("imm_shift", imm_shift, 32'hFFFE_0000);
    chk("mdr_load",  mdr,       32'h3C01_8000);
    chk("rt_lui",    {27'b0, rt}, 32'd1);

    // R-type field split
    mem_rdata = 32'h012A_40C2;
    step();
    chk("rs",    {27'b0, rs},    32'd9);
    chk("rt",    {27'b0, rt},    32'd10);
    chk("rd",    {27'b0, rd},    32'd8);
    chk("shamt", {27'b0, shamt}, 32'd3);
    chk("funct", {26'b0, funct}, 32'h02);
    chk("count_2", instr_count,  32'd2);

    // Data access through ALUOut at a misaligned address
    idle_inputs();
    alu_result = 32'h0000_0102;
    step();
    chk("alu_out_102", alu_out, 32'h102);
    chk("mem_addr_pc", mem_addr, TB_RESET_PC);
    IorD = 1;
    #1;
    chk("mem_addr_iord", mem_addr, 32'h102);
    step();
    chk("mis_set", {31'b0, misaligned}, 32'h1);
    IorD = 0; alu_result = 0;
    step(); step(); step();
    chk("mis_sticky", {31'b0, misaligned}, 32'h1);

    // Move pc away from reset, then reset during a fetch
    PCWrite = 1; PCSource = 2'b00; alu_result = 32'h2000;
    step();
    chk("pc_2000", pc, 32'h2000);
    rst = 1; PCWrite = 1; IRWrite = 1; mem_rdata = 32'hFFFF_FFFF; alu_result = 32'h3000;
    step();
    rst = 0;
    idle_inputs();
    chk("rst_pri_pc",    pc,          TB_RESET_PC);
    chk("rst_pri_count", instr_count, 32'h0);
    chk("rst_pri_op",    {26'b0, op_code}, 32'h0);
    chk("rst_pri_funct", {26'b0, funct},   32'h0);
    chk("rst_pri_mdr",   mdr,         32'h0);
    chk("rst_pri_mis",   {31'b0, misaligned}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
